// File: rtl/add_pipe_pkg.sv
// Shared definitions for the ALU add/sub pipeline: default widths and the
// ALU op codes the EXU maps onto this engine.
package add_pipe_pkg;

    localparam int ADD_WIDTH = 32;
    localparam int ADD_TAG_W = 5;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_SLT  = 2'd2,
        ALU_SLTU = 2'd3
    } alu_op_e;

    // SLT/SLTU are compares, so they run the adder in subtract mode.
    function automatic logic op_is_sub(input alu_op_e op);
        return op != ALU_ADD;
    endfunction

endpackage

// File: rtl/add_pipe_if.sv
// Operand/result bus of the add/sub pipeline.
// Valid/ready: a beat transfers on a rising edge where valid && ready are both
// high; the source holds valid and payload stable until that edge, and valid
// never waits on ready.
interface add_pipe_if
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int TAG_W = ADD_TAG_W
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_tag
    );
endinterface

// File: rtl/add_pipe_csel_block.sv
// W-bit adder producing both the carry-in-0 and carry-in-1 sums, each with
// its carry out in the top bit.
module add_pipe_csel_block #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W:0]   sum0,
    output logic [W:0]   sum1
);
    assign sum0 = {1'b0, a} + {1'b0, b};
    assign sum1 = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
endmodule

// File: rtl/add_pipe.sv
// Two-stage carry-select adder/subtractor: stage 1 registers the low-half sum
// and both high-half candidates, stage 2 selects and registers result + flags.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int LO_W  = WIDTH / 2,
    parameter int TAG_W = ADD_TAG_W
) (
    input logic       clk,
    input logic       rst_n,
    input logic       flush,
    add_pipe_if.slave bus
);
    localparam int HI_W = WIDTH - LO_W;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b_eff;
    logic             cin;
    logic [LO_W:0]    lo_d;
    logic [HI_W:0]    hi0_d;
    logic [HI_W:0]    hi1_d;

    logic             s1_valid;
    logic [LO_W-1:0]  s1_lo_sum;
    logic             s1_lo_cout;
    logic [HI_W:0]    s1_hi0;
    logic [HI_W:0]    s1_hi1;
    logic             s1_a_msb;
    logic             s1_b_msb;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_sum;
    logic             s2_cout;
    logic             s2_ovf;
    logic             s2_zero;
    logic [TAG_W-1:0] s2_tag;

    logic             s1_adv;
    logic             s2_adv;
    logic [HI_W:0]    hi_sel;
    logic [WIDTH-1:0] sum_d;
    logic             ovf_d;

    // Subtract is A + ~B + 1; the +1 enters as the low-half carry in.
    assign a     = bus.in_a;
    assign cin   = bus.in_sub;
    assign b_eff = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign lo_d  = {1'b0, a[LO_W-1:0]} + {1'b0, b_eff[LO_W-1:0]} + {{LO_W{1'b0}}, cin};

    add_pipe_csel_block #(.W(HI_W)) u_hi (
        .a    (a[WIDTH-1:LO_W]),
        .b    (b_eff[WIDTH-1:LO_W]),
        .sum0 (hi0_d),
        .sum1 (hi1_d)
    );

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    assign hi_sel = s1_lo_cout ? s1_hi1 : s1_hi0;
    assign sum_d  = {hi_sel[HI_W-1:0], s1_lo_sum};
    assign ovf_d  = (s1_a_msb == s1_b_msb) && (sum_d[WIDTH-1] != s1_a_msb);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_lo_sum  <= '0;
            s1_lo_cout <= 1'b0;
            s1_hi0     <= '0;
            s1_hi1     <= '0;
            s1_a_msb   <= 1'b0;
            s1_b_msb   <= 1'b0;
            s1_tag     <= '0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_lo_sum  <= lo_d[LO_W-1:0];
                s1_lo_cout <= lo_d[LO_W];
                s1_hi0     <= hi0_d;
                s1_hi1     <= hi1_d;
                s1_a_msb   <= a[WIDTH-1];
                s1_b_msb   <= b_eff[WIDTH-1];
                s1_tag     <= bus.in_tag;
            end
        end
    end

    // Result data only loads with a valid stage-1 op, so a stalled output never moves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_cout  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_tag   <= '0;
        end else if (flush) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sum  <= sum_d;
                s2_cout <= hi_sel[HI_W];
                s2_ovf  <= ovf_d;
                s2_zero <= ~|sum_d;
                s2_tag  <= s1_tag;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_sum   = s2_sum;
    assign bus.out_cout  = s2_cout;
    assign bus.out_ovf   = s2_ovf;
    assign bus.out_zero  = s2_zero;
    assign bus.out_tag   = s2_tag;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe: a 32/16 instance for directed cases and a 8/3 instance
// for a long randomized run, both scored against an arithmetic reference.
module tb_add_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    add_pipe_if #(.WIDTH(32), .TAG_W(5)) if32 ();
    add_pipe_if #(.WIDTH(8),  .TAG_W(5)) if8 ();

    add_pipe #(.WIDTH(32), .LO_W(16), .TAG_W(5)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (if32.slave)
    );

    add_pipe #(.WIDTH(8), .LO_W(3), .TAG_W(5)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (if8.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] exp32_q[$];
    logic [63:0] exp8_q[$];
    int          n_out32 = 0;
    int          n_out8  = 0;
    int          n_acc32 = 0;
    bit          hold32, hold8;
    logic [63:0] held32, held8;
    bit          track_low = 0;
    bit          low_seen  = 0;
    int          acc_at_low = -1;
    bit          drv8_done, drv32_done;
    int          snap;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packed {tag, sum, cout, ovf, zero} from plain integer arithmetic.
    function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic [4:0] tag);
        longint m, half, ua, ub, sa, sb, full, sr;
        logic cout, ovf, zero;
        m    = 64'sd1 <<< w;
        half = m / 2;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = (ua >= half) ? ua - m : ua;
        sb   = (ub >= half) ? ub - m : ub;
        if (sub) begin
            full = ua - ub;
            cout = (ua >= ub);
            sr   = sa - sb;
        end else begin
            full = ua + ub;
            cout = (full >= m);
            sr   = sa + sb;
        end
        full = (full + m) % m;
        ovf  = (sr >= half) || (sr < -half);
        zero = (full == 0);
        return (64'(tag) << (w + 3)) | (64'(full) << 3) | 64'({cout, ovf, zero});
    endfunction

    function automatic logic [63:0] obs32();
        return 64'({if32.out_tag, if32.out_sum, if32.out_cout, if32.out_ovf, if32.out_zero});
    endfunction

    function automatic logic [63:0] obs8();
        return 64'({if8.out_tag, if8.out_sum, if8.out_cout, if8.out_ovf, if8.out_zero});
    endfunction

    task automatic mon32();
        logic [63:0] obs;
        obs = obs32();
        if (hold32) check("stall_hold32", obs, held32);
        if (rst_n && if32.out_valid && if32.out_ready) begin
            n_out32++;
            n_cmp++;
            assert (exp32_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious32: observed result tag %0h, expected no result", if32.out_tag);
            end
            if (exp32_q.size() != 0) check("result32", obs, exp32_q.pop_front());
        end
        hold32 = rst_n && !flush && (if32.out_valid === 1'b1) && !if32.out_ready;
        held32 = obs;
        if (!rst_n || flush) exp32_q.delete();
        else if (if32.in_valid && if32.in_ready) begin
            n_acc32++;
            exp32_q.push_back(model(32, if32.in_a, if32.in_b, if32.in_sub, if32.in_tag));
        end
        if (track_low && !low_seen && !if32.in_ready) begin
            low_seen   = 1;
            acc_at_low = n_acc32;
        end
    endtask

    task automatic mon8();
        logic [63:0] obs;
        obs = obs8();
        if (hold8) check("stall_hold8", obs, held8);
        if (rst_n && if8.out_valid && if8.out_ready) begin
            n_out8++;
            n_cmp++;
            assert (exp8_q.size() != 0) else begin
                n_err++;
                $error("FAIL spurious8: observed result tag %0h, expected no result", if8.out_tag);
            end
            if (exp8_q.size() != 0) check("result8", obs, exp8_q.pop_front());
        end
        hold8 = rst_n && !flush && (if8.out_valid === 1'b1) && !if8.out_ready;
        held8 = obs;
        if (!rst_n || flush) exp8_q.delete();
        else if (if8.in_valid && if8.in_ready)
            exp8_q.push_back(model(8, 32'(if8.in_a), 32'(if8.in_b), if8.in_sub, if8.in_tag));
    endtask

    initial forever begin
        @(negedge clk);
        mon32();
        mon8();
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [4:0] tag);
        bit got = 0;
        if32.in_valid = 1'b1;
        if32.in_a     = a;
        if32.in_b     = b;
        if32.in_sub   = sub;
        if32.in_tag   = tag;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = if32.in_ready;
        end
        if (!got) check("accept32_timeout", 64'(got), 64'd1);
        step();
        if32.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic sub, input logic [4:0] tag);
        bit got = 0;
        if8.in_valid = 1'b1;
        if8.in_a     = a;
        if8.in_b     = b;
        if8.in_sub   = sub;
        if8.in_tag   = tag;
        for (int k = 0; k < 64 && !got; k++) begin
            @(negedge clk);
            got = if8.in_ready;
        end
        if (!got) check("accept8_timeout", 64'(got), 64'd1);
        step();
        if8.in_valid = 1'b0;
    endtask

    task automatic drain(input bit is8);
        for (int k = 0; k < 200; k++) begin
            if ((is8 ? exp8_q.size() : exp32_q.size()) == 0) break;
            @(negedge clk);
            #1;
        end
        if (is8) check("drain8", 64'(exp8_q.size()), 64'd0);
        else     check("drain32", 64'(exp32_q.size()), 64'd0);
    endtask

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 7))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h7F;
            3:       return 8'h80;
            4:       return 8'h07;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h0000_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        if32.in_valid = 1'b0; if32.in_a = '0; if32.in_b = '0; if32.in_sub = 1'b0; if32.in_tag = '0;
        if32.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_sub = 1'b0; if8.in_tag = '0;
        if8.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk); #1;
        check("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check("rst_in_ready", 64'(if32.in_ready), 64'd1);
        check("rst_outputs", obs32(), 64'd0);
        check("rst_out_valid8", 64'(if8.out_valid), 64'd0);
        step();

        // Wrap with latency: out_valid two cycles after presentation
        send32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 5'd3);
        @(negedge clk); #1;
        check("lat_not_yet", 64'(if32.out_valid), 64'd0);
        step();
        @(negedge clk); #1;
        check("lat_valid", 64'(if32.out_valid), 64'd1);
        check("wrap_sum", 64'(if32.out_sum), 64'h0);
        check("wrap_flags", 64'({if32.out_cout, if32.out_ovf, if32.out_zero}), 64'b101);
        step();

        // Directed corner vectors back to back
        send32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 5'd4);
        send32(32'h8000_0000, 32'h0000_0001, 1'b1, 5'd5);
        send32(32'h0000_0005, 32'h0000_0007, 1'b1, 5'd6);
        send32(32'h1234_ABCD, 32'h1234_ABCD, 1'b1, 5'd7);
        send32(32'h0000_FFFF, 32'h0000_0001, 1'b0, 5'd8);
        send8(8'h07, 8'h01, 1'b0, 5'd9);
        send8(8'hFF, 8'h01, 1'b0, 5'd10);
        send8(8'h80, 8'h01, 1'b1, 5'd11);
        drain(0);
        drain(1);
        step();

        // Back-pressure: tags 1..6, consumer stalls in cycles 3..7
        snap      = n_out32;
        n_acc32   = 0;
        low_seen  = 0;
        track_low = 1;
        fork
            for (int t = 1; t <= 6; t++) send32(32'(t * 16), 32'(t), 1'b0, 5'(t));
            begin
                repeat (2) @(posedge clk);
                #1 if32.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1 if32.out_ready = 1'b1;
            end
        join
        track_low = 0;
        drain(0);
        check("bp_ready_low_seen", 64'(low_seen), 64'd1);
        check("bp_accepts_before_low", 64'(acc_at_low), 64'd2);
        check("bp_result_count", 64'(n_out32 - snap), 64'd6);
        step();

        // Flush with two ops in flight and a new op presented
        if32.out_ready = 1'b0;
        send32(32'h1111_1111, 32'h2222_2222, 1'b0, 5'd20);
        send32(32'h3333_3333, 32'h0000_0001, 1'b1, 5'd21);
        flush = 1'b1;
        if32.in_valid = 1'b1; if32.in_a = 32'h5; if32.in_b = 32'h6; if32.in_tag = 5'd22;
        step();
        flush = 1'b0;
        if32.in_valid = 1'b0;
        @(negedge clk); #1;
        check("flush_out_valid", 64'(if32.out_valid), 64'd0);
        check("flush_in_ready", 64'(if32.in_ready), 64'd1);
        snap = n_out32;
        if32.out_ready = 1'b1;
        repeat (6) step();
        check("flush_no_results", 64'(n_out32 - snap), 64'd0);

        // Reset mid-operation
        if32.out_ready = 1'b0;
        send32(32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 5'd23);
        send32(32'hCAFE_F00D, 32'h0000_2222, 1'b1, 5'd24);
        rst_n = 1'b0;
        if32.in_valid = 1'b1; if32.in_tag = 5'd25;
        step();
        rst_n = 1'b1;
        if32.in_valid = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_out_valid", 64'(if32.out_valid), 64'd0);
        check("rst_mid_in_ready", 64'(if32.in_ready), 64'd1);
        check("rst_mid_outputs", obs32(), 64'd0);
        snap = n_out32;
        if32.out_ready = 1'b1;
        repeat (6) step();
        check("rst_mid_no_results", 64'(n_out32 - snap), 64'd0);

        // Randomized traffic with random back-pressure on both instances
        drv8_done  = 0;
        drv32_done = 0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send8(pick8(), pick8(), 1'($urandom), 5'($urandom));
                end
                drv8_done = 1;
            end
            begin
                while (!drv8_done) begin
                    if8.out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                if8.out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 3) == 0) step();
                    send32(pick32(), pick32(), 1'($urandom), 5'($urandom));
                end
                drv32_done = 1;
            end
            begin
                while (!drv32_done) begin
                    if32.out_ready = ($urandom_range(0, 2) != 0);
                    step();
                end
                if32.out_ready = 1'b1;
            end
        join
        drain(1);
        drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
